// File: rtl/execute_memory_unit_pkg.sv
// Shared constants and access-size helpers for the EX/MEM pipeline register.
package execute_memory_unit_pkg;

  localparam int unsigned RA_WIDTH = 5;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] FWD_NONE   = 2'b00;
  localparam logic [1:0] FWD_MEM_WB = 2'b01;
  localparam logic [1:0] FWD_EX_MEM = 2'b10;

  function automatic logic is_byte_access(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_BU);
  endfunction

  function automatic logic is_half_access(input logic [2:0] f3);
    return (f3 == F3_H) || (f3 == F3_HU);
  endfunction

  function automatic logic is_word_access(input logic [2:0] f3);
    return f3 == F3_W;
  endfunction

endpackage

// File: rtl/execute_memory_unit_forwarding.sv
// EX-hazard forwarding selects; EX/MEM result takes precedence over MEM/WB.
module forwarding_unit
  import execute_memory_unit_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = RA_WIDTH
) (
  input  logic                      ex_mem_valid,
  input  logic                      ex_mem_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] ex_mem_write_register,
  input  logic                      mem_wb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] mem_wb_write_register,
  input  logic [REG_ADDR_WIDTH-1:0] rs1,
  input  logic [REG_ADDR_WIDTH-1:0] rs2,
  output logic [1:0]                forward_a,
  output logic [1:0]                forward_b
);

  logic ex_mem_live;
  logic mem_wb_live;

  // x0 is hardwired to zero, so a write to it is never a forwarding source
  assign ex_mem_live = ex_mem_valid && ex_mem_reg_write && (ex_mem_write_register != '0);
  assign mem_wb_live = mem_wb_reg_write && (mem_wb_write_register != '0);

  always_comb begin
    forward_a = FWD_NONE;
    forward_b = FWD_NONE;
    if (ex_mem_live && (ex_mem_write_register == rs1)) begin
      forward_a = FWD_EX_MEM;
    end else if (mem_wb_live && (mem_wb_write_register == rs1)) begin
      forward_a = FWD_MEM_WB;
    end
    if (ex_mem_live && (ex_mem_write_register == rs2)) begin
      forward_b = FWD_EX_MEM;
    end else if (mem_wb_live && (mem_wb_write_register == rs2)) begin
      forward_b = FWD_MEM_WB;
    end
  end

endmodule

// File: rtl/execute_memory_unit.sv
// EX/MEM pipeline register: captures execute results, builds store strobes and
// lane-aligned store data, flags misaligned accesses and drives forwarding.
module execute_memory_unit
  import execute_memory_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = RA_WIDTH,
  parameter int unsigned COUNT_WIDTH    = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      valid_in,
  input  logic [DATA_WIDTH-1:0]     alu_result_in,
  input  logic [DATA_WIDTH-1:0]     store_data_in,
  input  logic [REG_ADDR_WIDTH-1:0] write_register_in,
  input  logic [2:0]                funct3_in,
  input  logic                      reg_write_in,
  input  logic                      mem_read_in,
  input  logic                      mem_write_in,
  input  logic                      mem_to_reg_in,
  input  logic [REG_ADDR_WIDTH-1:0] id_ex_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_ex_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] mem_wb_write_register,
  input  logic                      mem_wb_reg_write,
  output logic                      valid_out,
  output logic [DATA_WIDTH-1:0]     alu_result_out,
  output logic [DATA_WIDTH-1:0]     store_data_out,
  output logic [3:0]                byte_strobe_out,
  output logic [REG_ADDR_WIDTH-1:0] write_register_out,
  output logic [2:0]                funct3_out,
  output logic                      reg_write_out,
  output logic                      mem_read_out,
  output logic                      mem_write_out,
  output logic                      mem_to_reg_out,
  output logic                      misaligned_out,
  output logic [COUNT_WIDTH-1:0]    misaligned_count,
  output logic [1:0]                forward_a,
  output logic [1:0]                forward_b
);

  logic                  is_byte;
  logic                  is_half;
  logic                  is_word;
  logic [1:0]            addr_lo;
  logic                  misaligned_c;
  logic [3:0]            strobe_c;
  logic [DATA_WIDTH-1:0] store_c;

  assign addr_lo = alu_result_in[1:0];

  // Size decode, misalignment, strobes and lane replication for the incoming op
  always_comb begin
    is_byte      = is_byte_access(funct3_in);
    is_half      = is_half_access(funct3_in);
    is_word      = is_word_access(funct3_in);
    misaligned_c = valid_in && (mem_read_in || mem_write_in) &&
                   ((is_half && addr_lo[0]) || (is_word && (addr_lo != 2'b00)));
    strobe_c     = 4'b0000;
    if (valid_in && mem_write_in && !misaligned_c) begin
      if (is_byte) begin
        strobe_c = 4'(4'b0001 << addr_lo);
      end else if (is_half) begin
        strobe_c = addr_lo[1] ? 4'b1100 : 4'b0011;
      end else if (is_word) begin
        strobe_c = 4'b1111;
      end
    end
    store_c = store_data_in;
    if (is_byte) begin
      store_c = {(DATA_WIDTH/8){store_data_in[7:0]}};
    end else if (is_half) begin
      store_c = {(DATA_WIDTH/16){store_data_in[15:0]}};
    end
  end

  // Flush beats stall; the misaligned counter survives flushes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_out          <= 1'b0;
      alu_result_out     <= '0;
      store_data_out     <= '0;
      byte_strobe_out    <= 4'b0000;
      write_register_out <= '0;
      funct3_out         <= 3'b000;
      reg_write_out      <= 1'b0;
      mem_read_out       <= 1'b0;
      mem_write_out      <= 1'b0;
      mem_to_reg_out     <= 1'b0;
      misaligned_out     <= 1'b0;
      misaligned_count   <= '0;
    end else if (flush) begin
      valid_out          <= 1'b0;
      alu_result_out     <= '0;
      store_data_out     <= '0;
      byte_strobe_out    <= 4'b0000;
      write_register_out <= '0;
      funct3_out         <= 3'b000;
      reg_write_out      <= 1'b0;
      mem_read_out       <= 1'b0;
      mem_write_out      <= 1'b0;
      mem_to_reg_out     <= 1'b0;
      misaligned_out     <= 1'b0;
    end else if (!stall) begin
      valid_out          <= valid_in;
      alu_result_out     <= alu_result_in;
      store_data_out     <= store_c;
      byte_strobe_out    <= strobe_c;
      write_register_out <= write_register_in;
      funct3_out         <= funct3_in;
      reg_write_out      <= valid_in && reg_write_in && !misaligned_c;
      mem_read_out       <= valid_in && mem_read_in && !misaligned_c;
      mem_write_out      <= valid_in && mem_write_in && !misaligned_c;
      mem_to_reg_out     <= valid_in && mem_to_reg_in;
      misaligned_out     <= misaligned_c;
      if (misaligned_c && (misaligned_count != '1)) begin
        misaligned_count <= misaligned_count + COUNT_WIDTH'(1);
      end
    end
  end

  forwarding_unit #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_forwarding (
    .ex_mem_valid         (valid_out),
    .ex_mem_reg_write     (reg_write_out),
    .ex_mem_write_register(write_register_out),
    .mem_wb_reg_write     (mem_wb_reg_write),
    .mem_wb_write_register(mem_wb_write_register),
    .rs1                  (id_ex_rs1),
    .rs2                  (id_ex_rs2),
    .forward_a            (forward_a),
    .forward_b            (forward_b)
  );

endmodule

// File: tb/tb_execute_memory_unit.sv
// Bench for execute_memory_unit: directed corner cases plus random traffic
// checked every cycle against an access-level reference model.
module tb_execute_memory_unit;

  logic        clk;
  logic        reset;
  logic        stall, flush, valid_in;
  logic [31:0] alu_in, sd_in;
  logic [4:0]  rd_in;
  logic [2:0]  f3_in;
  logic        rw_in, mr_in, mw_in, m2r_in;
  logic [4:0]  rs1, rs2, wb_rd;
  logic        wb_rw;

  logic        valid_out;
  logic [31:0] alu_result_out, store_data_out;
  logic [3:0]  byte_strobe_out;
  logic [4:0]  write_register_out;
  logic [2:0]  funct3_out;
  logic        reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out;
  logic        misaligned_out;
  logic [7:0]  misaligned_count;
  logic [1:0]  forward_a, forward_b;

  execute_memory_unit dut (
    .clk                  (clk),
    .reset                (reset),
    .stall                (stall),
    .flush                (flush),
    .valid_in             (valid_in),
    .alu_result_in        (alu_in),
    .store_data_in        (sd_in),
    .write_register_in    (rd_in),
    .funct3_in            (f3_in),
    .reg_write_in         (rw_in),
    .mem_read_in          (mr_in),
    .mem_write_in         (mw_in),
    .mem_to_reg_in        (m2r_in),
    .id_ex_rs1            (rs1),
    .id_ex_rs2            (rs2),
    .mem_wb_write_register(wb_rd),
    .mem_wb_reg_write     (wb_rw),
    .valid_out            (valid_out),
    .alu_result_out       (alu_result_out),
    .store_data_out       (store_data_out),
    .byte_strobe_out      (byte_strobe_out),
    .write_register_out   (write_register_out),
    .funct3_out           (funct3_out),
    .reg_write_out        (reg_write_out),
    .mem_read_out         (mem_read_out),
    .mem_write_out        (mem_write_out),
    .mem_to_reg_out       (mem_to_reg_out),
    .misaligned_out       (misaligned_out),
    .misaligned_count     (misaligned_count),
    .forward_a            (forward_a),
    .forward_b            (forward_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference state of the EX/MEM register
  bit        m_valid, m_rw, m_mr, m_mw, m_m2r, m_mis;
  bit [31:0] m_alu, m_sd;
  int        m_strb;
  bit [4:0]  m_rd;
  bit [2:0]  m_f3;
  int        m_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear(input bit keep_cnt);
    m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0; m_mis = 0;
    m_alu = 0; m_sd = 0; m_strb = 0; m_rd = 0; m_f3 = 0;
    if (!keep_cnt) m_cnt = 0;
  endtask

  // Applies one rising edge to the model using the inputs held at that edge
  task automatic model_update();
    int a;
    bit isb, ish, isw;
    if (!reset) begin
      model_clear(0);
    end else if (flush) begin
      model_clear(1);
    end else if (!stall) begin
      a   = int'(alu_in % 4);
      isb = (f3_in == 3'd0) || (f3_in == 3'd4);
      ish = (f3_in == 3'd1) || (f3_in == 3'd5);
      isw = (f3_in == 3'd2);
      m_valid = valid_in; m_alu = alu_in; m_rd = rd_in; m_f3 = f3_in;
      if (isb)      m_sd = {24'd0, sd_in[7:0]} * 32'h01010101;
      else if (ish) m_sd = {16'd0, sd_in[15:0]} * 32'h00010001;
      else          m_sd = sd_in;
      m_mis = valid_in && (mr_in || mw_in) && ((ish && (a % 2 == 1)) || (isw && a != 0));
      m_rw  = valid_in && rw_in && !m_mis;
      m_mr  = valid_in && mr_in && !m_mis;
      m_mw  = valid_in && mw_in && !m_mis;
      m_m2r = valid_in && m2r_in;
      m_strb = 0;
      if (m_mw) begin
        if (isb)      m_strb = 1 << a;
        else if (ish) m_strb = (a >= 2) ? 12 : 3;
        else if (isw) m_strb = 15;
      end
      if (m_mis && m_cnt < 255) m_cnt++;
    end
  endtask

  function automatic int fwd(input bit [4:0] rs);
    if (m_valid && m_rw && m_rd != 0 && m_rd == rs) return 2;
    if (wb_rw && wb_rd != 0 && wb_rd == rs) return 1;
    return 0;
  endfunction

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid_out", 32'(valid_out), 32'(m_valid));
      chk("alu_result_out", alu_result_out, m_alu);
      chk("store_data_out", store_data_out, m_sd);
      chk("byte_strobe_out", 32'(byte_strobe_out), 32'(m_strb));
      chk("write_register_out", 32'(write_register_out), 32'(m_rd));
      chk("funct3_out", 32'(funct3_out), 32'(m_f3));
      chk("reg_write_out", 32'(reg_write_out), 32'(m_rw));
      chk("mem_read_out", 32'(mem_read_out), 32'(m_mr));
      chk("mem_write_out", 32'(mem_write_out), 32'(m_mw));
      chk("mem_to_reg_out", 32'(mem_to_reg_out), 32'(m_m2r));
      chk("misaligned_out", 32'(misaligned_out), 32'(m_mis));
      chk("misaligned_count", 32'(misaligned_count), 32'(m_cnt));
      chk("forward_a", 32'(forward_a), 32'(fwd(rs1)));
      chk("forward_b", 32'(forward_b), 32'(fwd(rs2)));
    end
  end

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_op(input bit v, input bit [31:0] a, input bit [31:0] d, input bit [2:0] f3,
                        input bit rw, input bit mr, input bit mw, input bit m2r, input bit [4:0] rd);
    valid_in = v; alu_in = a; sd_in = d; f3_in = f3;
    rw_in = rw; mr_in = mr; mw_in = mw; m2r_in = m2r; rd_in = rd;
  endtask

  task automatic rand_inputs();
    int k;
    k = $urandom_range(0, 5);
    stall = ($urandom_range(0, 99) < 15);
    flush = ($urandom_range(0, 99) < 8);
    set_op($urandom_range(0, 99) < 80, $urandom, $urandom,
           (k == 0) ? 3'd0 : (k == 1) ? 3'd1 : (k == 2) ? 3'd2 : (k == 3) ? 3'd4 : (k == 4) ? 3'd5 : 3'd3,
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)));
    rs1 = 5'($urandom_range(0, 3));
    rs2 = 5'($urandom_range(0, 3));
    wb_rd = 5'($urandom_range(0, 3));
    wb_rw = 1'($urandom);
  endtask

  initial begin
    reset = 1'b0; stall = 0; flush = 0;
    set_op(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rs1 = 0; rs2 = 0; wb_rd = 0; wb_rw = 0;
    model_clear(0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 32'(valid_out), 32'd0);
    chk("reset_count", 32'(misaligned_count), 32'd0);
    reset = 1'b1;
    chk_en = 1'b1;

    // SB to the top byte lane
    set_op(1, 32'h1003, 32'h000000AB, 3'd0, 0, 0, 1, 0, 5'd0);
    step();
    chk("sb_strobe", 32'(byte_strobe_out), 32'h8);
    chk("sb_data", store_data_out, 32'hABABABAB);
    chk("sb_mem_write", 32'(mem_write_out), 32'd1);

    // Misaligned LW suppresses controls and counts
    set_op(1, 32'h1002, 32'h0, 3'd2, 1, 1, 0, 1, 5'd7);
    step();
    chk("lw_mis", 32'(misaligned_out), 32'd1);
    chk("lw_mem_read", 32'(mem_read_out), 32'd0);
    chk("lw_reg_write", 32'(reg_write_out), 32'd0);
    chk("lw_count1", 32'(misaligned_count), 32'd1);
    repeat (4) step();
    chk("lw_count5", 32'(misaligned_count), 32'd5);

    // Asynchronous reset between edges
    set_op(1, 32'h40, 32'h0, 3'd2, 1, 0, 0, 0, 5'd3);
    step();
    chk("pre_reset_valid", 32'(valid_out), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("async_valid", 32'(valid_out), 32'd0);
    chk("async_count", 32'(misaligned_count), 32'd0);
    chk("async_alu", alu_result_out, 32'd0);
    chk("async_reg_write", 32'(reg_write_out), 32'd0);
    model_clear(0);
    step();
    reset = 1'b1;

    // Counter saturation
    set_op(1, 32'h1002, 32'h0, 3'd2, 1, 1, 0, 1, 5'd7);
    repeat (256) step();
    chk("count_sat", 32'(misaligned_count), 32'hFF);
    step();
    chk("count_hold", 32'(misaligned_count), 32'hFF);

    // Stall holds, then flush wins over stall
    set_op(1, 32'h2000, 32'h12345678, 3'd2, 0, 0, 1, 0, 5'd0);
    step();
    chk("sw_strobe", 32'(byte_strobe_out), 32'hF);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_op(1, $urandom, $urandom, 3'd0, 1, 0, 1, 0, 5'd9);
      step();
    end
    chk("stall_alu", alu_result_out, 32'h2000);
    chk("stall_data", store_data_out, 32'h12345678);
    chk("stall_mem_write", 32'(mem_write_out), 32'd1);
    flush = 1'b1;
    step();
    chk("flush_valid", 32'(valid_out), 32'd0);
    chk("flush_mem_write", 32'(mem_write_out), 32'd0);
    flush = 1'b0; stall = 1'b0;

    // Forwarding priority and x0
    set_op(1, 32'h0, 32'h0, 3'd2, 1, 0, 0, 0, 5'd5);
    step();
    rs1 = 5'd5; wb_rd = 5'd5; wb_rw = 1'b1;
    #1;
    chk("fwd_ex_mem", 32'(forward_a), 32'd2);
    set_op(0, 32'h0, 32'h0, 3'd2, 1, 0, 0, 0, 5'd5);
    step();
    chk("fwd_mem_wb", 32'(forward_a), 32'd1);
    set_op(1, 32'h0, 32'h0, 3'd2, 1, 0, 0, 0, 5'd0);
    step();
    wb_rd = 5'd0; rs2 = 5'd0;
    #1;
    chk("fwd_x0", 32'(forward_b), 32'd0);

    // Bubble store produces no write or strobes
    set_op(0, 32'h10, 32'hFF, 3'd0, 0, 0, 1, 0, 5'd1);
    step();
    chk("bubble_mem_write", 32'(mem_write_out), 32'd0);
    chk("bubble_strobe", 32'(byte_strobe_out), 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      step();
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
